// File: rtl/palette_ram_arbiter_if.sv
// Palette RAM arbiter bus bundle: video read port, CPU req/ack port, RAM port.
// Latency: none (signal bundle only).
// Backpressure: carried by cpu_req/cpu_ack; the video port is never stalled.
// Ports (slave = arbiter side):
//   cmpblk2, vid_rd, vid_addr, vid_data, vid_valid          video pipeline
//   cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_rdata, cpu_ack CPU bus
//   wbuf_full                                               write-buffer status
//   ram_en, ram_we, ram_addr, ram_wdata, ram_rdata          single-port RAM
interface palette_ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cmpblk2;
  logic              vid_rd;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              wbuf_full;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cmpblk2, vid_rd, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vid_data, vid_valid, cpu_rdata, cpu_ack, wbuf_full,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output cmpblk2, vid_rd, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vid_data, vid_valid, cpu_rdata, cpu_ack, wbuf_full,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/palette_ram_arbiter.sv
// Shares one single-port palette RAM between the video pipeline and the CPU bus.
// Latency: video read 2 cycles (vid_rd in N -> vid_valid in N+2); CPU write acked next cycle.
// Backpressure: video never stalls; CPU held off (no ack) while the write buffer is full
//   or until a read can be issued after buffered writes drain.
// Ports: clk, rst_n (async active-low), bus (palette_ram_arbiter_if.slave).
// Option: define PALETTE_BLANK_ONLY_EN to restrict CPU RAM access to blanking (cmpblk2=1).
module palette_ram_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  palette_ram_arbiter_if.slave  bus
);
  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_DRAIN = 3'd1;
  localparam logic [2:0] S_RD_ISSUE = 3'd2;
  localparam logic [2:0] S_RD_CAPT  = 3'd3;
  localparam logic [2:0] S_ACK      = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_wb_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] r_wb_data [WBUF_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_ack;
  logic              r_vid_tag;
  logic              r_vid_valid;
  logic [DATA_W-1:0] r_vid_data;
  logic [DATA_W-1:0] r_cpu_rdata;

  logic              w_elig;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_cpu_rd_gnt;
  logic              w_ram_en;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;

`ifdef PALETTE_BLANK_ONLY_EN
  // CPU traffic only touches the RAM during blanking so palette changes never tear.
  assign w_elig = ~bus.vid_rd & bus.cmpblk2;
`else
  logic w_unused_blank;
  assign w_unused_blank = bus.cmpblk2;
  assign w_elig         = ~bus.vid_rd;
`endif

  assign w_empty      = (r_count == '0);
  assign w_cpu_rd_gnt = rst_n & (r_state == S_RD_ISSUE) & w_elig;
  // A pending CPU read owns every eligible slot; buffered writes only use the rest.
  assign w_pop        = rst_n & w_elig & ~w_empty & (r_state != S_RD_ISSUE);
  // The ack cycle never accepts a new request, so a still-high cpu_req is not re-pushed.
  assign w_push       = bus.cpu_req & bus.cpu_we & ~r_full & ~r_ack;

  // RAM port mux; held quiet while reset is asserted so no stray write escapes.
  always_comb begin
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    if (rst_n) begin
      if (bus.vid_rd) begin
        w_ram_en   = 1'b1;
        w_ram_addr = bus.vid_addr;
      end else if (w_cpu_rd_gnt) begin
        w_ram_en   = 1'b1;
        w_ram_addr = bus.cpu_addr;
      end else if (w_pop) begin
        w_ram_en    = 1'b1;
        w_ram_we    = 1'b1;
        w_ram_addr  = r_wb_addr[r_rd_ptr];
        w_ram_wdata = r_wb_data[r_rd_ptr];
      end
    end
  end

  // Buffer storage needs no reset: entries are only read when the count says valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wb_addr[r_wr_ptr] <= bus.cpu_addr;
      r_wb_data[r_wr_ptr] <= bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10: begin
          r_count <= r_count + CNT_W'(1);
          r_full  <= (r_count + CNT_W'(1)) == CNT_W'(WBUF_DEPTH);
        end
        2'b01: begin
          r_count <= r_count - CNT_W'(1);
          r_full  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // CPU read sequencer. Draining first guarantees a read sees every earlier write.
  // The RD_CAPT state itself is the tag marking ram_rdata as CPU data that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ack       <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      r_ack <= w_push | (r_state == S_RD_CAPT);
      case (r_state)
        S_IDLE:     if (bus.cpu_req && !bus.cpu_we && !r_ack) r_state <= S_RD_DRAIN;
        S_RD_DRAIN: if (w_empty) r_state <= S_RD_ISSUE;
        S_RD_ISSUE: if (w_cpu_rd_gnt) r_state <= S_RD_CAPT;
        S_RD_CAPT: begin
          r_cpu_rdata <= bus.ram_rdata;
          r_state     <= S_ACK;
        end
        S_ACK:      r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  // Video return path: tag follows the read by one cycle to pick up ram_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vid_tag   <= 1'b0;
      r_vid_valid <= 1'b0;
      r_vid_data  <= '0;
    end else begin
      r_vid_tag   <= bus.vid_rd;
      r_vid_valid <= r_vid_tag;
      if (r_vid_tag) r_vid_data <= bus.ram_rdata;
    end
  end

  assign bus.ram_en    = w_ram_en;
  assign bus.ram_we    = w_ram_we;
  assign bus.ram_addr  = w_ram_addr;
  assign bus.ram_wdata = w_ram_wdata;
  assign bus.vid_data  = r_vid_data;
  assign bus.vid_valid = r_vid_valid;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_ack   = r_ack;
  assign bus.wbuf_full = r_full;
endmodule

// File: tb/tb_palette_ram_arbiter.sv
// Directed bench for palette_ram_arbiter with a behavioural 1-cycle-latency RAM.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_palette_ram_arbiter;
  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  palette_ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  palette_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .WBUF_DEPTH(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with a private preload port
  logic [7:0] mem [256];
  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_dat;
  logic [7:0] wlog [$];
  logic [7:0] cap_rdata;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_dat;
    else if (bus.ram_en && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= mem[bus.ram_addr];
  end

  always @(posedge clk)
    if (rst_n && bus.ram_en && bus.ram_we) wlog.push_back(bus.ram_addr);

  function automatic logic [7:0] init_val(input int a);
    case (a)
      'h3C:    return 8'hA5;
      'h55:    return 8'hC3;
      'h66:    return 8'h3A;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_start(input logic we, input logic [7:0] a, input logic [7:0] d);
    cyc();
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  // Returns at the falling edge of the ack cycle, or of the last cycle waited.
  task automatic wait_ack(input int max_cyc, output logic acked);
    acked = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus.cpu_ack) begin
        acked     = 1'b1;
        cap_rdata = bus.cpu_rdata;
        break;
      end
      if (i < max_cyc - 1) cyc();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cpu_ack"},   bus.cpu_ack,   0);
    check({tag, " vid_valid"}, bus.vid_valid, 0);
    check({tag, " vid_data"},  bus.vid_data,  0);
    check({tag, " cpu_rdata"}, bus.cpu_rdata, 0);
    check({tag, " ram_en"},    bus.ram_en,    0);
    check({tag, " ram_we"},    bus.ram_we,    0);
    check({tag, " wbuf_full"}, bus.wbuf_full, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic ok;
    bool_init: begin
      rst_n         = 1'b0;
      bus.cmpblk2   = 1'b1;
      bus.vid_rd    = 1'b0;
      bus.vid_addr  = 8'h00;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 8'h00;
      bus.cpu_wdata = 8'h00;
      ld_en         = 1'b1;
      ld_addr       = 8'h00;
      ld_dat        = 8'h00;
    end

    // Preload RAM while the arbiter is held in reset
    for (int a = 0; a < 256; a++) begin
      ld_addr = 8'(a);
      ld_dat  = init_val(a);
      cyc();
    end
    ld_en = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    // Video read: 2-cycle latency
    cyc();
    bus.vid_rd   = 1'b1;
    bus.vid_addr = 8'h3C;
    @(negedge clk);
    check("v1 ram_en",   bus.ram_en,   1);
    check("v1 ram_we",   bus.ram_we,   0);
    check("v1 ram_addr", bus.ram_addr, 8'h3C);
    cyc();
    bus.vid_rd = 1'b0;
    @(negedge clk);
    check("v1 N+1 valid", bus.vid_valid, 0);
    cyc();
    @(negedge clk);
    check("v1 N+2 valid", bus.vid_valid, 1);
    check("v1 N+2 data",  bus.vid_data,  8'hA5);
    cyc();
    @(negedge clk);
    check("v1 N+3 valid", bus.vid_valid, 0);

    // Five writes while video holds the RAM
    cyc();
    bus.vid_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_start(1'b1, 8'h10 + 8'(i), 8'h01 + 8'(i));
      wait_ack(6, ok);
      check("w4 ack", ok, 1);
    end
    check("w4 full", bus.wbuf_full, 1);
    cpu_start(1'b1, 8'h14, 8'h05);
    wait_ack(6, ok);
    check("w5 no ack while full", ok, 0);
    check("w5 still full", bus.wbuf_full, 1);
    check("w5 no drain under video", wlog.size(), 0);
    cyc();
    bus.vid_rd = 1'b0;
    wait_ack(10, ok);
    check("w5 ack after drain starts", ok, 1);
    cyc();
    bus.cpu_req = 1'b0;
    repeat (8) cyc();
    @(negedge clk);
    check("w5 drain count", wlog.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < wlog.size()) check("w5 drain order", wlog[i], 8'h10 + 8'(i));
      check("w5 ram value", mem[8'h10 + 8'(i)], 8'h01 + 8'(i));
    end
    check("w5 full cleared", bus.wbuf_full, 0);

    // Read-after-write coherence
    wlog.delete();
    cyc();
    bus.vid_rd = 1'b1;
    cpu_start(1'b1, 8'h20, 8'h77);
    wait_ack(6, ok);
    check("raw write ack", ok, 1);
    cpu_start(1'b0, 8'h20, 8'h00);
    wait_ack(5, ok);
    check("raw no ack before drain", ok, 0);
    cyc();
    bus.vid_rd = 1'b0;
    wait_ack(12, ok);
    check("raw read ack", ok, 1);
    check("raw rdata", cap_rdata, 8'h77);
    check("raw drained first", wlog.size(), 1);
    cyc();
    bus.cpu_req = 1'b0;

    // CPU read interleaved with alternating video reads
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      bus.vid_rd   = ~i[0];
      bus.vid_addr = 8'h66;
      if (i == 0) begin
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 8'h55;
      end
      @(negedge clk);
      if (bus.vid_rd) check("alt video owns port", bus.ram_addr, 8'h66);
      if (bus.vid_valid) check("alt vid_data", bus.vid_data, 8'h3A);
      if (bus.cpu_ack) begin
        ok = 1'b1;
        check("alt cpu_rdata", bus.cpu_rdata, 8'hC3);
        break;
      end
    end
    check("alt cpu ack seen", ok, 1);
    cyc();
    bus.cpu_req = 1'b0;
    bus.vid_rd  = 1'b0;

    // Reset with buffered writes and a pending read
    cyc();
    bus.vid_rd   = 1'b1;
    bus.vid_addr = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      cpu_start(1'b1, 8'h30 + 8'(i), 8'h09 + 8'(i));
      wait_ack(6, ok);
      check("rst pre write ack", ok, 1);
    end
    cpu_start(1'b0, 8'h33, 8'h00);
    @(negedge clk);
    check("rst pre vid_valid", bus.vid_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst mid");
    wlog.delete();
    bus.cpu_req = 1'b0;
    bus.vid_rd  = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    repeat (10) cyc();
    @(negedge clk);
    check("rst no write after release", wlog.size(), 0);
    check("rst ram 0x30 untouched", mem[8'h30], 8'h00);
    check("rst full", bus.wbuf_full, 0);
    check("rst no ack", bus.cpu_ack, 0);

    // Blanking gate on CPU access
    wlog.delete();
    cyc();
    bus.cmpblk2 = 1'b0;
    cpu_start(1'b1, 8'h40, 8'h99);
    wait_ack(6, ok);
    check("blank write ack", ok, 1);
    cyc();
    bus.cpu_req = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
`ifdef PALETTE_BLANK_ONLY_EN
    check("blank no drain outside blanking", wlog.size(), 0);
    cyc();
    bus.cmpblk2 = 1'b1;
    @(negedge clk);
    check("blank drain ram_we", bus.ram_we, 1);
    check("blank drain addr", bus.ram_addr, 8'h40);
    cyc();
    @(negedge clk);
    check("blank drained", wlog.size(), 1);
    check("blank ram value", mem[8'h40], 8'h99);
`else
    check("blank drains regardless", wlog.size(), 1);
    check("blank ram value", mem[8'h40], 8'h99);
    bus.cmpblk2 = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
